// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, flag indices and op-class decode for alu_pipe_flags
package alu_pkg;

  // Logic opcodes (fs[4] = 0); any other fs[4]=0 code yields zero
  localparam logic [4:0] FS_ZERO  = 5'b00000;
  localparam logic [4:0] FS_PASSA = 5'b01100;
  localparam logic [4:0] FS_NOTA  = 5'b00011;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01110;
  localparam logic [4:0] FS_XOR   = 5'b00110;
  localparam logic [4:0] FS_ONES  = 5'b01111;

  // Shift kinds carried in fs[1:0] when fs[4:3] = 11
  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  // Bit positions inside flags = {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    CLS_LOGIC = 2'd0,
    CLS_ARITH = 2'd1,
    CLS_SHIFT = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] fs);
    if (!fs[4]) return CLS_LOGIC;
    if (!fs[3]) return CLS_ARITH;
    return CLS_SHIFT;
  endfunction

endpackage

// File: rtl/alu_barrel_shift.sv
// rtl/alu_barrel_shift.sv - combinational shl/shr/asr/rol by a variable amount with carry-out
module alu_barrel_shift
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         kind,
  output logic [WIDTH-1:0]   res,
  output logic               carry
);

  // One extra bit on the side data leaves from captures the last bit shifted out
  // (and reads 0 for a zero shift amount).
  logic [WIDTH:0]        shl_w;
  logic [WIDTH:0]        shr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]      rol_w;

  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;
  assign asr_w = $signed({a, 1'b0}) >>> shamt;
  assign rol_w = (a << shamt) | (a >> (WIDTH - int'(shamt)));

  // Select the shift kind; rotate reports the bit that wrapped into position 0
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (kind)
      SH_SHL: begin
        res   = shl_w[WIDTH-1:0];
        carry = shl_w[WIDTH];
      end
      SH_SHR: begin
        res   = shr_w[WIDTH:1];
        carry = shr_w[0];
      end
      SH_ASR: begin
        res   = asr_w[WIDTH:1];
        carry = asr_w[0];
      end
      default: begin
        res   = rol_w;
        carry = rol_w[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe_flags.sv
// rtl/alu_pipe_flags.sv - two-stage valid/ready ALU with Z/N/C/V flags; ALU_STICKY_OVF_EN adds ovf_sticky
module alu_pipe_flags
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       fs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [3:0]       flags
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             ovf_sticky,
  input  logic             clr_sticky
`endif
);

  logic             rdy_en_q;
  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_fs_q, s1_fs_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  op_class_e        s1_cls_q, s1_cls_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [3:0]       flags_q, flags_d;

  logic             adv1, adv2;
  logic [WIDTH-1:0] a_p, y_sel, logic_res, sh_res, res_f;
  logic [WIDTH:0]   sum;
  logic             sh_c, res_c, res_v;
  logic [SHAMT_W-1:0] shamt;
  logic [3:0]       res_flags;

  // Each stage moves when its downstream slot is empty or being drained.
  assign adv2      = ~s2_valid_q | out_ready;
  assign adv1      = ~s1_valid_q | adv2;
  assign in_ready  = adv1 & rdy_en_q;
  assign out_valid = s2_valid_q;
  assign f         = f_q;
  assign flags     = flags_q;

  assign shamt = s1_fs_q[2] ? s1_b_q[SHAMT_W-1:0] : {{(SHAMT_W-1){1'b0}}, 1'b1};

  alu_barrel_shift #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .a     (s1_a_q),
    .shamt (shamt),
    .kind  (s1_fs_q[1:0]),
    .res   (sh_res),
    .carry (sh_c)
  );

  // Stage-2 datapath: arithmetic, logic and shift results plus their flags
  always_comb begin
    a_p = s1_fs_q[0] ? ~s1_a_q : s1_a_q;
    case (s1_fs_q[2:1])
      2'b00:   y_sel = '0;
      2'b01:   y_sel = '1;
      2'b10:   y_sel = s1_b_q;
      default: y_sel = ~s1_b_q;
    endcase
    sum = {1'b0, a_p} + {1'b0, y_sel} + {{WIDTH{1'b0}}, s1_cin_q};

    case (s1_fs_q)
      FS_PASSA: logic_res = s1_a_q;
      FS_NOTA:  logic_res = ~s1_a_q;
      FS_AND:   logic_res = s1_a_q & s1_b_q;
      FS_OR:    logic_res = s1_a_q | s1_b_q;
      FS_XOR:   logic_res = s1_a_q ^ s1_b_q;
      FS_ONES:  logic_res = '1;
      default:  logic_res = '0;
    endcase

    res_f = logic_res;
    res_c = 1'b0;
    res_v = 1'b0;
    case (s1_cls_q)
      CLS_ARITH: begin
        res_f = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_p[WIDTH-1] == y_sel[WIDTH-1]) & (sum[WIDTH-1] != a_p[WIDTH-1]);
      end
      CLS_SHIFT: begin
        res_f = sh_res;
        res_c = sh_c;
      end
      default: ;
    endcase

    res_flags        = '0;
    res_flags[FLG_Z] = (res_f == '0);
    res_flags[FLG_N] = res_f[WIDTH-1];
    res_flags[FLG_C] = res_c;
    res_flags[FLG_V] = res_v;
  end

  // Next-state for both stages; each holds its contents while stalled
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fs_d    = s1_fs_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_cls_d   = s1_cls_q;
    s2_valid_d = s2_valid_q;
    f_d        = f_q;
    flags_d    = flags_q;
    if (adv1) begin
      s1_valid_d = in_valid & in_ready;
      if (in_valid & in_ready) begin
        s1_fs_d  = fs;
        s1_a_d   = a;
        s1_b_d   = b;
        s1_cin_d = cin;
        s1_cls_d = op_class(fs);
      end
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        f_d     = res_f;
        flags_d = res_flags;
      end
    end
  end

  // Pipeline registers; reset flushes both stages and blocks input for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_fs_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_cls_q   <= CLS_LOGIC;
      s2_valid_q <= 1'b0;
      f_q        <= '0;
      flags_q    <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_fs_q    <= s1_fs_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s1_cls_q   <= s1_cls_d;
      s2_valid_q <= s2_valid_d;
      f_q        <= f_d;
      flags_q    <= flags_d;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Sticky overflow: an overflowing output transfer wins over a clear in the same cycle
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky) ovf_sticky_d = 1'b0;
    if (s2_valid_q & out_ready & flags_q[FLG_V]) ovf_sticky_d = 1'b1;
  end

  // Sticky overflow register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule
